// File: rtl/adc2_conv_ctrl_if.sv
// Result handshake between the conversion sequencer and the digital back end.
// The sequencer is the master: it presents a result and waits for ready.
interface adc2_conv_ctrl_if;
    logic       result_valid;
    logic       result_ready;
    logic [1:0] result_data;
    logic       result_err;

    modport master (
        output result_valid,
        output result_data,
        output result_err,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_data,
        input  result_err,
        output result_ready
    );
endinterface

// File: rtl/adc2_conv_ctrl.sv
// Conversion sequencer for the 2-bit flash ADC front end.
// Each sample is: track (TRACK_CYC), hold/settle (SETTLE_CYC), one latch cycle.
// Bubble codes are discarded and retried up to MAX_RETRY times in a row.
// 2^AVG_LOG2 good samples are averaged (floor) into one result.
// Every output is a register loaded from the next-state decode, so the
// strobes line up exactly with the state they belong to.
module adc2_conv_ctrl #(
    parameter int TRACK_CYC  = 4,
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 2,
    parameter int MAX_RETRY  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cont,
    output logic                    track_o,
    output logic                    comp_latch_o,
    input  logic [2:0]              therm_i,
    adc2_conv_ctrl_if.master        res,
    output logic                    busy,
    output logic                    bubble_err,
    output logic [7:0]              err_cnt,
    input  logic                    err_clr
);
    localparam int ACC_W   = AVG_LOG2 + 2;
    localparam int SCNT_W  = AVG_LOG2 + 1;
    localparam int NSAMP   = 1 << AVG_LOG2;
    localparam int CYC_MAX = (TRACK_CYC > SETTLE_CYC) ? TRACK_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CYC_MAX + 1);
    localparam int RTRY_W  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRACK,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cyc_reg, cyc_next;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic [SCNT_W-1:0]   scnt_reg, scnt_next;
    logic [RTRY_W-1:0]   retry_reg, retry_next;
    logic                track_reg, track_next;
    logic                latch_reg, latch_next;
    logic                valid_reg, valid_next;
    logic [1:0]          data_reg, data_next;
    logic                rerr_reg, rerr_next;
    logic                busy_reg, busy_next;
    logic                bubble_reg, bubble_next;
    logic [7:0]          ecnt_reg, ecnt_next;

    // A code is a legal thermometer code when no set bit sits above a clear one.
    logic [1:0]          mono;
    logic                code_ok;
    logic [1:0]          code_val;

    genvar gi;
    generate
        for (gi = 1; gi < 3; gi++) begin : g_mono
            assign mono[gi-1] = !therm_i[gi] || therm_i[gi-1];
        end
    endgenerate

    assign code_ok  = &mono;
    assign code_val = 2'(therm_i[0]) + 2'(therm_i[1]) + 2'(therm_i[2]);

    logic [ACC_W-1:0]  acc_sum;
    logic [SCNT_W-1:0] scnt_inc;
    logic [RTRY_W-1:0] retry_inc;
    logic              bad_capture;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_next  = state_reg;
        cyc_next    = cyc_reg;
        acc_next    = acc_reg;
        scnt_next   = scnt_reg;
        retry_next  = retry_reg;
        valid_next  = valid_reg;
        data_next   = data_reg;
        rerr_next   = rerr_reg;
        bubble_next = bubble_reg;
        ecnt_next   = ecnt_reg;
        bad_capture = 1'b0;
        acc_sum     = acc_reg + ACC_W'(code_val);
        scnt_inc    = scnt_reg + SCNT_W'(1);
        retry_inc   = retry_reg + RTRY_W'(1);

        case (state_reg)
            S_IDLE: begin
                if (start || cont) begin
                    state_next = S_TRACK;
                    cyc_next   = '0;
                    acc_next   = '0;
                    scnt_next  = '0;
                    retry_next = '0;
                end
            end
            S_TRACK: begin
                if (cyc_reg == CNT_W'(TRACK_CYC - 1)) begin
                    state_next = S_SETTLE;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_reg + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cyc_reg == CNT_W'(SETTLE_CYC - 1)) begin
                    state_next = S_CAPTURE;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_reg + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                cyc_next = '0;
                if (code_ok) begin
                    acc_next   = acc_sum;
                    scnt_next  = scnt_inc;
                    retry_next = '0;
                    if (scnt_inc == SCNT_W'(NSAMP)) begin
                        state_next = S_DONE;
                        valid_next = 1'b1;
                        data_next  = acc_sum[AVG_LOG2 +: 2];
                        rerr_next  = 1'b0;
                    end else begin
                        state_next = S_TRACK;
                    end
                end else begin
                    bad_capture = 1'b1;
                    retry_next  = retry_inc;
                    if (retry_inc <= RTRY_W'(MAX_RETRY)) begin
                        state_next = S_TRACK;
                    end else begin
                        state_next = S_DONE;
                        valid_next = 1'b1;
                        data_next  = 2'd0;
                        rerr_next  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (res.result_ready) begin
                    valid_next = 1'b0;
                    rerr_next  = 1'b0;
                    if (cont) begin
                        state_next = S_TRACK;
                        cyc_next   = '0;
                        acc_next   = '0;
                        scnt_next  = '0;
                        retry_next = '0;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Clearing wins over a bad capture landing in the same cycle.
        if (err_clr) begin
            bubble_next = 1'b0;
            ecnt_next   = 8'd0;
        end else if (bad_capture) begin
            bubble_next = 1'b1;
            if (ecnt_reg != 8'hFF) begin
                ecnt_next = ecnt_reg + 8'd1;
            end
        end

        track_next = (state_next == S_TRACK);
        latch_next = (state_next == S_CAPTURE);
        busy_next  = (state_next != S_IDLE);
    end

    // State and output registers; reset discards any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cyc_reg    <= '0;
            acc_reg    <= '0;
            scnt_reg   <= '0;
            retry_reg  <= '0;
            track_reg  <= 1'b0;
            latch_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            data_reg   <= 2'd0;
            rerr_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            bubble_reg <= 1'b0;
            ecnt_reg   <= 8'd0;
        end else begin
            state_reg  <= state_next;
            cyc_reg    <= cyc_next;
            acc_reg    <= acc_next;
            scnt_reg   <= scnt_next;
            retry_reg  <= retry_next;
            track_reg  <= track_next;
            latch_reg  <= latch_next;
            valid_reg  <= valid_next;
            data_reg   <= data_next;
            rerr_reg   <= rerr_next;
            busy_reg   <= busy_next;
            bubble_reg <= bubble_next;
            ecnt_reg   <= ecnt_next;
        end
    end

    assign track_o          = track_reg;
    assign comp_latch_o     = latch_reg;
    assign res.result_valid = valid_reg;
    assign res.result_data  = data_reg;
    assign res.result_err   = rerr_reg;
    assign busy             = busy_reg;
    assign bubble_err       = bubble_reg;
    assign err_cnt          = ecnt_reg;
endmodule

// File: tb/tb_adc2_conv_ctrl.sv
// Bench for adc2_conv_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a timeline model.
module tb_adc2_conv_ctrl;
    localparam int TRACK_CYC  = 4;
    localparam int SETTLE_CYC = 2;
    localparam int AVG_LOG2   = 2;
    localparam int MAX_RETRY  = 3;
    localparam int SAMPLE_LEN = TRACK_CYC + SETTLE_CYC + 1;
    localparam int NSAMP      = 1 << AVG_LOG2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] therm_i = 3'd0;
    logic       track_o, comp_latch_o, busy, bubble_err;
    logic [7:0] err_cnt;

    adc2_conv_ctrl_if res_if();

    adc2_conv_ctrl #(
        .TRACK_CYC (TRACK_CYC),
        .SETTLE_CYC(SETTLE_CYC),
        .AVG_LOG2  (AVG_LOG2),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .track_o     (track_o),
        .comp_latch_o(comp_latch_o),
        .therm_i     (therm_i),
        .res         (res_if),
        .busy        (busy),
        .bubble_err  (bubble_err),
        .err_cnt     (err_cnt),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Value of each comparator pattern; -1 marks a bubble code.
    function automatic int decode(input logic [2:0] t);
        case (t)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b011:  return 2;
            3'b111:  return 3;
            default: return -1;
        endcase
    endfunction

    // ---------------- comparator stimulus ----------------
    logic [2:0] therm_q[$];
    logic [2:0] therm_fill = 3'b011;
    bit         rand_mode  = 1'b0;

    // Present a code during latch cycles; garbage elsewhere must be ignored.
    initial begin
        forever begin
            @(negedge clk);
            if (comp_latch_o) begin
                if (therm_q.size() > 0) therm_i = therm_q.pop_front();
                else if (rand_mode) begin
                    if ($urandom_range(0, 99) < 70) begin
                        case ($urandom_range(0, 3))
                            0: therm_i = 3'b000;
                            1: therm_i = 3'b001;
                            2: therm_i = 3'b011;
                            default: therm_i = 3'b111;
                        endcase
                    end else therm_i = 3'($urandom);
                end else therm_i = therm_fill;
            end else begin
                therm_i = 3'($urandom);
            end
        end
    end

    // ---------------- timeline model + per-cycle compare ----------------
    // m_phase: 0 idle, 1 sampling (m_pos = cycle index inside the sample), 2 result held.
    int m_phase = 0, m_pos = 0, m_sum = 0, m_n = 0, m_retry = 0;
    int m_data = 0, m_err = 0, m_bubble = 0, m_cnt = 0, m_conv = 0;
    logic s_rst, s_start, s_cont, s_ready, s_clr;
    logic [2:0] s_therm;

    initial begin
        forever begin
            int v;
            bit bad;
            @(posedge clk);
            s_rst = rst; s_start = start; s_cont = cont;
            s_ready = res_if.result_ready; s_therm = therm_i; s_clr = err_clr;
            #1;
            bad = 1'b0;
            if (s_rst) begin
                m_phase = 0; m_pos = 0; m_sum = 0; m_n = 0; m_retry = 0;
                m_data = 0; m_err = 0; m_bubble = 0; m_cnt = 0;
            end else begin
                case (m_phase)
                    0: if (s_start || s_cont) begin
                        m_phase = 1; m_pos = 0; m_sum = 0; m_n = 0; m_retry = 0;
                    end
                    1: if (m_pos == SAMPLE_LEN - 1) begin
                        v = decode(s_therm);
                        if (v >= 0) begin
                            m_sum += v; m_n++; m_retry = 0;
                            if (m_n == NSAMP) begin
                                m_phase = 2; m_data = m_sum / NSAMP; m_err = 0;
                            end else m_pos = 0;
                        end else begin
                            bad = 1'b1; m_retry++;
                            if (m_retry <= MAX_RETRY) m_pos = 0;
                            else begin m_phase = 2; m_data = 0; m_err = 1; end
                        end
                    end else m_pos++;
                    default: if (s_ready) begin
                        m_conv++;
                        $display("conv %0d: data=%0d err=%0d", m_conv, m_data, m_err);
                        m_err = 0;
                        if (s_cont) begin
                            m_phase = 1; m_pos = 0; m_sum = 0; m_n = 0; m_retry = 0;
                        end else m_phase = 0;
                    end
                endcase
                if (s_clr) begin m_bubble = 0; m_cnt = 0; end
                else if (bad) begin
                    m_bubble = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            chk("track_o", track_o, int'(m_phase == 1 && m_pos < TRACK_CYC));
            chk("comp_latch_o", comp_latch_o, int'(m_phase == 1 && m_pos == SAMPLE_LEN - 1));
            chk("busy", busy, int'(m_phase != 0));
            chk("result_valid", res_if.result_valid, int'(m_phase == 2));
            chk("result_err", res_if.result_err, m_err);
            if (m_phase == 2) chk("result_data", res_if.result_data, m_data);
            chk("bubble_err", bubble_err, m_bubble);
            chk("err_cnt", err_cnt, m_cnt);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic run_conv(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (res_if.result_valid !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int guard;
        res_if.result_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_track", track_o, 0);
        chk("rst_valid", res_if.result_valid, 0);
        chk("rst_data", res_if.result_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: constant 011, result 2 after 29 cycles, back to idle next cycle
        therm_fill = 3'b011;
        run_conv(cyc);
        chk("s1_latency", cyc, 29);
        chk("s1_data", res_if.result_data, 2);
        chk("s1_err", res_if.result_err, 0);
        @(negedge clk);
        chk("s1_idle", busy, 0);

        // 2: 0+1+2+3 = 6, floor(6/4) = 1
        therm_q = '{3'b000, 3'b001, 3'b011, 3'b111};
        run_conv(cyc);
        chk("s2_latency", cyc, 29);
        chk("s2_data", res_if.result_data, 1);
        chk("s2_err_cnt", err_cnt, 0);
        @(negedge clk);

        // 3: one bubble then four 111 -> one extra sample period
        therm_q = '{3'b101, 3'b111, 3'b111, 3'b111, 3'b111};
        run_conv(cyc);
        chk("s3_latency", cyc, 36);
        chk("s3_data", res_if.result_data, 3);
        chk("s3_err", res_if.result_err, 0);
        chk("s3_err_cnt", err_cnt, 1);
        chk("s3_bubble", bubble_err, 1);
        @(negedge clk);

        // 4: persistent bubble -> abort after 1+MAX_RETRY captures
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        res_if.result_ready = 1'b0;
        therm_fill = 3'b010;
        run_conv(cyc);
        chk("s4_latency", cyc, 29);
        chk("s4_err", res_if.result_err, 1);
        chk("s4_data", res_if.result_data, 0);
        chk("s4_err_cnt", err_cnt, 4);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("s4_clr_cnt", err_cnt, 0);
        chk("s4_clr_bubble", bubble_err, 0);
        chk("s4_result_err_kept", res_if.result_err, 1);
        res_if.result_ready = 1'b1;
        @(negedge clk);

        // 5: backpressure with ignored start pulses, then continuous restart
        res_if.result_ready = 1'b0;
        therm_fill = 3'b111;
        run_conv(cyc);
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("s5_hold_data", res_if.result_data, 3);
            chk("s5_hold_valid", res_if.result_valid, 1);
        end
        start = 1'b0;
        cont = 1'b1;
        res_if.result_ready = 1'b1;
        @(negedge clk);
        chk("s5_cont_track", track_o, 1);
        chk("s5_cont_valid", res_if.result_valid, 0);
        cont = 1'b0;
        guard = 0;
        while (res_if.result_valid !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("s5_cont_done", res_if.result_valid, 1);
        @(negedge clk);
        chk("s5_stop_idle", busy, 0);

        // 6: async reset during SETTLE after a bubble was counted
        therm_q = '{3'b010};
        therm_fill = 3'b011;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(busy && !track_o && !comp_latch_o && err_cnt != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("s6_reached_settle", int'(guard < 100), 1);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_track", track_o, 0);
        chk("s6_async_busy", busy, 0);
        chk("s6_async_err_cnt", err_cnt, 0);
        chk("s6_async_bubble", bubble_err, 0);
        chk("s6_async_valid", res_if.result_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("s6_stays_idle", busy, 0);

        // randomized traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            start = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) cont = ~cont;
            res_if.result_ready = 1'($urandom_range(0, 2) != 0);
            err_clr = 1'($urandom_range(0, 99) == 0);
            rst = 1'($urandom_range(0, 1499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        cont = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
